// File: rtl/jtframe_sdram_arb4.sv
// jtframe_sdram_arb4: 4-port SDRAM arbiter (req_rd/req_wr/req_addr/req_din in, ack/dst/rdy per port out, sdram_* controller side, busy, sticky err)
module jtframe_sdram_arb4 #(
  parameter int SDRAMW  = 22,
  parameter int MAXWAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          req_rd,
  input  logic [3:0]          req_wr,
  input  logic [4*SDRAMW-1:0] req_addr,
  input  logic [63:0]         req_din,
  output logic [3:0]          ack,
  output logic [3:0]          dst,
  output logic [3:0]          rdy,
  output logic                sdram_rd,
  output logic                sdram_wr,
  output logic [SDRAMW-1:0]   sdram_addr,
  output logic [15:0]         sdram_din,
  input  logic                sdram_ack,
  input  logic                data_dst,
  input  logic                data_rdy,
  output logic                busy,
  output logic                err
);
  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  state_t          state;
  logic [1:0]      sel, win;
  logic [3:0]      pend, aged;
  logic [3:0][3:0] cnt;
  function automatic logic [1:0] lowest(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction
  assign pend = req_rd | req_wr;
  always_comb begin
    aged = 4'b0;
    for (int i = 0; i < 4; i++) aged[i] = pend[i] && cnt[i] == 4'(MAXWAIT);
  end
  assign win  = lowest(|aged ? aged : pend);
  assign busy = state != IDLE;
  assign dst  = state == DATA ? {3'b0, data_dst} << sel : 4'b0;
  assign rdy  = state == DATA ? {3'b0, data_rdy} << sel : 4'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 2'd0;
      ack        <= 4'b0;
      sdram_rd   <= 1'b0;
      sdram_wr   <= 1'b0;
      sdram_addr <= '0;
      sdram_din  <= 16'd0;
      err        <= 1'b0;
      cnt        <= '0;
    end else begin
      ack <= 4'b0;
      if ((data_rdy && state != DATA) || (sdram_ack && state != REQ)) err <= 1'b1;
      for (int i = 0; i < 4; i++)
        if (!pend[i]) cnt[i] <= 4'd0;
        else if (state == IDLE) cnt[i] <= 2'(i) == win ? 4'd0 : cnt[i] == 4'(MAXWAIT) ? cnt[i] : cnt[i] + 4'd1;
      case (state)
        IDLE: if (|pend) begin
          sdram_addr <= req_addr[win*SDRAMW +: SDRAMW];
          sdram_din  <= req_din[win*16 +: 16];
          sdram_wr   <= req_wr[win];
          sdram_rd   <= !req_wr[win];
          sel        <= win;
          state      <= REQ;
        end
        REQ: if (sdram_ack) begin
          sdram_rd <= 1'b0;
          sdram_wr <= 1'b0;
          ack      <= 4'b1 << sel;
          state    <= DATA;
        end
        DATA: if (data_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
